// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs and the stall/wash strobes back to the pipeline.
// The pipeline is the master and the controller is the slave.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_uses_hilo;
    logic       ex_memrd;
    logic [4:0] ex_regdst_addr;
    logic       md_start;
    logic       mem_req;
    logic       mem_ack;
    logic       exc_req;
    logic       pa_pcifid;
    logic       pa_idexmemwr;
    logic       wash_ifid_o;
    logic       wash_idex_o;
    logic       wash_exmem_o;
    logic       wash_memwr_o;
    logic       md_busy;
    logic       bus_err;
    logic [1:0] ctrl_state;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_uses_hilo,
               ex_memrd, ex_regdst_addr, md_start, mem_req, mem_ack, exc_req,
        input  pa_pcifid, pa_idexmemwr, wash_ifid_o, wash_idex_o, wash_exmem_o,
               wash_memwr_o, md_busy, bus_err, ctrl_state
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_uses_hilo,
               ex_memrd, ex_regdst_addr, md_start, mem_req, mem_ack, exc_req,
        output pa_pcifid, pa_idexmemwr, wash_ifid_o, wash_idex_o, wash_exmem_o,
               wash_memwr_o, md_busy, bus_err, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use and HI/LO bubbles,
// data-memory wait with timeout, and exception flushes. Strobes are combinational.
module pipe_hazard_ctrl #(
    parameter int MD_LAT      = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int         MD_W   = $clog2(MD_LAT + 1);
    localparam logic [7:0] TMO    = 8'(MEM_TIMEOUT);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      wait_q, wait_d;
    logic [MD_W-1:0] md_q, md_d;
    logic            bus_err_q, bus_err_d;

    logic load_use, hilo_hz, timeout, kill, mem_stall;

    assign load_use = hz.ex_memrd && (hz.ex_regdst_addr != 5'd0) &&
                      ((hz.id_uses_rs && (hz.id_rs_addr == hz.ex_regdst_addr)) ||
                       (hz.id_uses_rt && (hz.id_rt_addr == hz.ex_regdst_addr)));
    assign hilo_hz  = hz.id_uses_hilo && (md_q != '0);
    assign timeout  = (state_q == MEMWAIT) && (wait_q == TMO) && !hz.mem_ack;
    // FLUSH swallows any exception request; the wrong path is already being discarded.
    assign kill      = (state_q != FLUSH) && (hz.exc_req || timeout);
    assign mem_stall = !kill && !hz.mem_ack &&
                       (((state_q == RUN) && hz.mem_req) || (state_q == MEMWAIT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            md_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            md_q      <= md_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bus_err_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (kill) begin
                    state_d = FLUSH;
                    wait_d  = '0;
                end else if (mem_stall) begin
                    state_d = MEMWAIT;
                    wait_d  = 8'd1;
                end
            end
            MEMWAIT: begin
                if (kill) begin
                    state_d   = FLUSH;
                    wait_d    = '0;
                    bus_err_d = timeout && !hz.exc_req;
                end else if (hz.mem_ack) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase

        // A mult/div only issues if its EX instruction actually advances and survives.
        if (hz.md_start && !hz.pa_idexmemwr && !hz.wash_exmem_o) begin
            md_d = MD_LOAD;
        end else if (md_q != '0) begin
            md_d = md_q - 1'b1;
        end else begin
            md_d = '0;
        end
    end

    always_comb begin
        hz.pa_pcifid    = 1'b0;
        hz.pa_idexmemwr = 1'b0;
        hz.wash_ifid_o  = 1'b0;
        hz.wash_idex_o  = 1'b0;
        hz.wash_exmem_o = 1'b0;
        hz.wash_memwr_o = 1'b0;
        if (!reset_n) begin
            hz.wash_ifid_o  = 1'b1;
            hz.wash_idex_o  = 1'b1;
            hz.wash_exmem_o = 1'b1;
            hz.wash_memwr_o = 1'b1;
        end else if (state_q == FLUSH) begin
            hz.wash_ifid_o = 1'b1;
        end else if (kill) begin
            hz.wash_ifid_o  = 1'b1;
            hz.wash_idex_o  = 1'b1;
            hz.wash_exmem_o = 1'b1;
        end else if (mem_stall) begin
            hz.pa_pcifid    = 1'b1;
            hz.pa_idexmemwr = 1'b1;
            hz.wash_memwr_o = 1'b1;
        end else if ((state_q == RUN) && (load_use || hilo_hz)) begin
            hz.pa_pcifid   = 1'b1;
            hz.wash_idex_o = 1'b1;
        end
    end

    assign hz.md_busy    = (md_q != '0);
    assign hz.bus_err    = bus_err_q;
    assign hz.ctrl_state = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic against a cycle-level behavioural model of the controller.
module tb_pipe_hazard_ctrl;
    localparam int MD_LAT = 3;
    localparam int TO     = 4;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_cmp;
    int   n_bad;

    // model state: pipeline mode (0 run, 1 memory wait, 2 flush), cycles waited,
    // mult/div cycles remaining, bus error flag
    int m_mode, m_wait, m_md;
    bit m_berr;
    int x_mode, x_wait, x_md;
    bit x_berr;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .MEM_TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] strobes();
        return {bus.pa_pcifid, bus.pa_idexmemwr, bus.wash_ifid_o,
                bus.wash_idex_o, bus.wash_exmem_o, bus.wash_memwr_o};
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic quiet();
        bus.id_rs_addr     = 5'd0;
        bus.id_rt_addr     = 5'd0;
        bus.id_uses_rs     = 1'b0;
        bus.id_uses_rt     = 1'b0;
        bus.id_uses_hilo   = 1'b0;
        bus.ex_memrd       = 1'b0;
        bus.ex_regdst_addr = 5'd0;
        bus.md_start       = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_ack        = 1'b0;
        bus.exc_req        = 1'b0;
    endtask

    // Evaluate the model on the current inputs, compare all outputs, stage next state.
    task automatic check();
        logic [5:0] exp_s;
        bit load_use, tmo, stall, kill;
        @(negedge clk);
        n_vec++;
        stall = 0;
        kill  = 0;
        load_use = bus.ex_memrd && bus.ex_regdst_addr != 0 &&
                   ((bus.id_uses_rs && bus.id_rs_addr == bus.ex_regdst_addr) ||
                    (bus.id_uses_rt && bus.id_rt_addr == bus.ex_regdst_addr));
        x_mode = m_mode;
        x_wait = m_wait;
        x_berr = 0;
        if (!reset_n) begin
            exp_s = 6'b001111;
            x_mode = 0; x_wait = 0;
        end else if (m_mode == 2) begin
            exp_s = 6'b001000;
            x_mode = 0; x_wait = 0;
        end else begin
            tmo = (m_mode == 1) && (m_wait == TO) && !bus.mem_ack;
            if (bus.exc_req || tmo) begin
                kill = 1;
                exp_s = 6'b001110;
                x_mode = 2; x_wait = 0;
                x_berr = tmo && !bus.exc_req;
            end else if (m_mode == 1) begin
                if (bus.mem_ack) begin
                    exp_s = 6'b000000;
                    x_mode = 0; x_wait = 0;
                end else begin
                    stall = 1;
                    exp_s = 6'b110001;
                    x_wait = m_wait + 1;
                end
            end else if (bus.mem_req && !bus.mem_ack) begin
                stall = 1;
                exp_s = 6'b110001;
                x_mode = 1; x_wait = 1;
            end else if (load_use || (bus.id_uses_hilo && m_md > 0)) begin
                exp_s = 6'b100100;
            end else begin
                exp_s = 6'b000000;
            end
        end
        if (!reset_n)                                   x_md = 0;
        else if (bus.md_start && !stall && !kill)       x_md = MD_LAT;
        else                                            x_md = (m_md > 0) ? m_md - 1 : 0;

        cmp("strobes", 8'(strobes()), 8'(exp_s));
        cmp("ctrl_state", 8'(bus.ctrl_state), 8'(m_mode));
        cmp("md_busy", 8'(bus.md_busy), 8'(m_md > 0));
        cmp("bus_err", 8'(bus.bus_err), 8'(m_berr));
    endtask

    task automatic tick();
        @(posedge clk);
        m_mode = x_mode;
        m_wait = x_wait;
        m_md   = x_md;
        m_berr = x_berr;
        #1;
    endtask

    initial begin
        n_vec = 0; n_cmp = 0; n_bad = 0;
        m_mode = 0; m_wait = 0; m_md = 0; m_berr = 0;
        reset_n = 1'b0;
        quiet();

        // reset
        check(); cmp("rst_wash", 8'(strobes()), 8'h0f); tick();
        reset_n = 1'b1;
        check();
        cmp("rst_state", 8'(bus.ctrl_state), 8'd0);
        cmp("rst_md_busy", 8'(bus.md_busy), 8'd0);
        cmp("rst_bus_err", 8'(bus.bus_err), 8'd0);
        tick();

        // load-use on $5, then cleared, then $0 destination
        bus.ex_memrd = 1'b1; bus.ex_regdst_addr = 5'd5;
        bus.id_rs_addr = 5'd5; bus.id_uses_rs = 1'b1;
        bus.id_rt_addr = 5'd7; bus.id_uses_rt = 1'b1;
        check(); cmp("lu_bubble", 8'(strobes()), 8'h24); tick();
        bus.ex_memrd = 1'b0;
        check(); cmp("lu_clear", 8'(strobes()), 8'h00); tick();
        bus.ex_memrd = 1'b1; bus.ex_regdst_addr = 5'd0; bus.id_rs_addr = 5'd0;
        check(); cmp("lu_r0", 8'(strobes()), 8'h00); tick();
        quiet();

        // memory wait: three cycles without ack, then ack
        for (int i = 0; i < 4; i++) begin
            bus.mem_req = 1'b1;
            bus.mem_ack = (i == 3);
            check();
            cmp("mw_pa", 8'({bus.pa_pcifid, bus.pa_idexmemwr}), (i < 3) ? 8'd3 : 8'd0);
            cmp("mw_state", 8'(bus.ctrl_state), (i == 0) ? 8'd0 : 8'd1);
            tick();
        end
        quiet();
        check(); cmp("mw_run", 8'(bus.ctrl_state), 8'd0); tick();

        // timeout: ack never arrives
        for (int i = 0; i < 5; i++) begin
            bus.mem_req = 1'b1;
            check();
            if (i == 4) begin
                cmp("to_wash", 8'(strobes()), 8'h0e);
                cmp("to_state", 8'(bus.ctrl_state), 8'd1);
            end
            tick();
        end
        quiet();
        check();
        cmp("to_flush", 8'(bus.ctrl_state), 8'd2);
        cmp("to_bus_err", 8'(bus.bus_err), 8'd1);
        cmp("to_flush_wash", 8'(strobes()), 8'h08);
        tick();
        check();
        cmp("to_run", 8'(bus.ctrl_state), 8'd0);
        cmp("to_bus_err_pulse", 8'(bus.bus_err), 8'd0);
        tick();

        // HI/LO: mult issued, MFHI waits out MD_LAT cycles
        bus.md_start = 1'b1;
        check(); tick();
        bus.md_start = 1'b0; bus.id_uses_hilo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check();
            cmp("hilo_busy", 8'(bus.md_busy), (i < 3) ? 8'd1 : 8'd0);
            cmp("hilo_bubble", 8'(strobes()), (i < 3) ? 8'h24 : 8'h00);
            tick();
        end
        quiet();

        // exception beats memory wait and load-use; FLUSH ignores everything
        bus.exc_req = 1'b1; bus.mem_req = 1'b1;
        bus.ex_memrd = 1'b1; bus.ex_regdst_addr = 5'd9;
        bus.id_rt_addr = 5'd9; bus.id_uses_rt = 1'b1;
        check(); cmp("exc_wash", 8'(strobes()), 8'h0e); tick();
        check();
        cmp("exc_flush_state", 8'(bus.ctrl_state), 8'd2);
        cmp("exc_flush_wash", 8'(strobes()), 8'h08);
        tick();
        quiet();
        check(); cmp("exc_run", 8'(bus.ctrl_state), 8'd0); tick();

        // reset while waiting on memory with a mult/div in flight
        bus.md_start = 1'b1;
        check(); tick();
        bus.md_start = 1'b0; bus.mem_req = 1'b1;
        check(); tick();
        reset_n = 1'b0;
        check(); cmp("rmw_wash", 8'(strobes()), 8'h0f); tick();
        reset_n = 1'b1; quiet();
        check();
        cmp("rmw_state", 8'(bus.ctrl_state), 8'd0);
        cmp("rmw_md_busy", 8'(bus.md_busy), 8'd0);
        cmp("rmw_bus_err", 8'(bus.bus_err), 8'd0);
        tick();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset_n            = ($urandom_range(0, 59) != 0);
            bus.id_rs_addr     = 5'($urandom_range(0, 3));
            bus.id_rt_addr     = 5'($urandom_range(0, 3));
            bus.id_uses_rs     = 1'($urandom_range(0, 1));
            bus.id_uses_rt     = 1'($urandom_range(0, 1));
            bus.id_uses_hilo   = ($urandom_range(0, 3) == 0);
            bus.ex_memrd       = ($urandom_range(0, 2) == 0);
            bus.ex_regdst_addr = 5'($urandom_range(0, 3));
            bus.md_start       = ($urandom_range(0, 7) == 0);
            bus.mem_req        = ($urandom_range(0, 3) == 0);
            bus.mem_ack        = ($urandom_range(0, 3) == 0);
            bus.exc_req        = ($urandom_range(0, 19) == 0);
            check();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
